demux_one_to_four_tdm: RTL
==========================

DEMUX_ONE_TO_FOUR_TDM -- requirements
Module: demux_one_to_four_tdm

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1, giving the width of one channel word.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port DIN, input, DATA_W bits, the time-multiplexed input word.
REQ-005 The block SHALL have port DIN_VALID, input, 1 bit: DIN carries a word this cycle.
REQ-006 The block SHALL have port SYNC, input, 1 bit: qualified by DIN_VALID, marks the slot-0 word of a frame.
REQ-007 The block SHALL have port DOUT, output, 4*DATA_W bits: slot k occupies bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port DOUT_VALID, output, 1 bit, a one-cycle pulse when DOUT updates.
REQ-009 The block SHALL have port SEL, output, 2 bits, the slot index the next accepted word is written to.
REQ-010 The block SHALL have port LOCKED, output, 1 bit, high in state LOCK.
REQ-011 The block SHALL have port SYNC_ERR, output, 1 bit, a one-cycle pulse on a framing violation.
REQ-012 The block SHALL have port FRAME_CNT, output, 8 bits, the count of completed frames.

Function
REQ-013 The block SHALL implement a two-state FSM, HUNT and LOCK; a word is accepted only on a CLK edge with DIN_VALID=1.
REQ-014 In HUNT, words with SYNC=0 SHALL be discarded and SEL SHALL hold 0.
REQ-015 In HUNT, an accepted word with SYNC=1 SHALL be stored in shadow slot 0, set SEL=1, and move the FSM to LOCK.
REQ-016 In LOCK with SEL!=0 and SYNC=0, an accepted word SHALL be stored in shadow slot SEL, and SEL SHALL increment modulo 4.
REQ-017 When the slot-3 word is accepted, DOUT SHALL load all four slots atomically on the next edge, with DOUT_VALID=1 for exactly that one cycle; SEL SHALL wrap to 0.
REQ-018 DOUT SHALL hold its last complete frame until the next completed frame; partial frames SHALL never appear on DOUT.
REQ-019 In LOCK with SEL=0, an accepted word with SYNC=1 SHALL start a new frame: store in slot 0, SEL=1, no error.
REQ-020 In LOCK with SEL=0, an accepted word with SYNC=0 SHALL pulse SYNC_ERR, be discarded, and return the FSM to HUNT.
REQ-021 In LOCK with SEL!=0, an accepted word with SYNC=1 SHALL pulse SYNC_ERR, discard the partial frame, store the word in slot 0, set SEL=1, and remain in LOCK.
REQ-022 SYNC with DIN_VALID=0 SHALL be ignored; cycles with DIN_VALID=0 SHALL change no state.
REQ-023 FRAME_CNT SHALL increment, wrapping 255->0, in the same cycle DOUT_VALID pulses.
REQ-024 SYNC_ERR and DOUT_VALID SHALL be registered outputs.
REQ-025 The slot-3 acceptance that completes a frame and any following word SHALL proceed back-to-back with no dead cycle.

Reset
REQ-026 While RST=1, independent of CLK, the FSM SHALL be HUNT, and SEL, DOUT, shadow slots, DOUT_VALID, SYNC_ERR, LOCKED and FRAME_CNT SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require a new SYNC word.

Verification
REQ-028 With DATA_W=1 after reset, DIN_VALID continuously high, send SYNC=1 with bits 1,0,1,1 -> one cycle after the 4th word, DOUT=4'b1101, DOUT_VALID pulses once, FRAME_CNT=1, SEL=0.
REQ-029 Send words with SYNC=0 while in HUNT, then a SYNC frame 0,1,1,0 -> the leading words are ignored, then DOUT=4'b0110 and LOCKED=1.
REQ-030 Send a SYNC frame 1,1 then a new SYNC word -> SYNC_ERR pulses, DOUT is unchanged, SEL=1, LOCKED=1.
REQ-031 After a complete frame, send a word with SYNC=0 at SEL=0 -> SYNC_ERR pulses, LOCKED=0, SEL=0.
REQ-032 Assert RST after 2 words of a frame -> all outputs 0 immediately; a frame sent after release is decoded correctly.
REQ-033 Send 256 back-to-back frames with DIN_VALID gaps inserted randomly -> FRAME_CNT wraps to 0 and every DOUT matches the sent frame.

Source files
------------

// File: rtl/demux_one_to_four_tdm.sv
// One-to-four time-division demultiplexer.
// A SYNC-marked word starts a frame in slot 0; the following three accepted words fill
// slots 1..3. A completed frame is presented on DOUT atomically with a one-cycle
// DOUT_VALID pulse. Framing violations pulse SYNC_ERR. A misplaced SYNC resynchronises
// the frame. A missing SYNC at a frame boundary drops the block back to hunting.
module demux_one_to_four_tdm #(
  parameter int unsigned DATA_W = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                DIN_VALID,
  input  logic                SYNC,
  output logic [4*DATA_W-1:0] DOUT,
  output logic                DOUT_VALID,
  output logic [1:0]          SEL,
  output logic                LOCKED,
  output logic                SYNC_ERR,
  output logic [7:0]          FRAME_CNT
);

  typedef enum logic [0:0] {
    StHunt,
    StLock
  } state_e;

  state_e                r_state;
  logic [1:0]            r_sel;
  // Slots 0..2 of the frame under assembly; slot 3 goes straight from DIN into DOUT.
  logic [3*DATA_W-1:0]   r_shadow;
  logic [4*DATA_W-1:0]   r_dout;
  logic                  r_dout_valid;
  logic                  r_sync_err;
  logic [7:0]            r_frame_cnt;

  // Frame FSM: accepts a word only when DIN_VALID is high; pulses clear on every edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= StHunt;
      r_sel        <= 2'd0;
      r_shadow     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      if (DIN_VALID) begin
        case (r_state)
          StHunt: begin
            // Words without SYNC are dropped while hunting.
            if (SYNC) begin
              r_shadow[0 +: DATA_W] <= DIN;
              r_sel                 <= 2'd1;
              r_state               <= StLock;
            end
          end
          StLock: begin
            if (SYNC) begin
              // SYNC mid-frame abandons the partial frame and restarts at slot 0.
              r_sync_err            <= (r_sel != 2'd0);
              r_shadow[0 +: DATA_W] <= DIN;
              r_sel                 <= 2'd1;
            end else begin
              case (r_sel)
                2'd0: begin
                  // Expected a frame start but SYNC was missing: lose lock.
                  r_sync_err <= 1'b1;
                  r_state    <= StHunt;
                end
                2'd1: begin
                  r_shadow[DATA_W +: DATA_W] <= DIN;
                  r_sel                      <= 2'd2;
                end
                2'd2: begin
                  r_shadow[2*DATA_W +: DATA_W] <= DIN;
                  r_sel                        <= 2'd3;
                end
                default: begin
                  // Slot 3 completes the frame; publish all four slots in one edge.
                  r_dout       <= {DIN, r_shadow};
                  r_dout_valid <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 8'd1;
                  r_sel        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            r_state <= StHunt;
            r_sel   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_valid;
  assign SEL        = r_sel;
  assign LOCKED     = (r_state == StLock);
  assign SYNC_ERR   = r_sync_err;
  assign FRAME_CNT  = r_frame_cnt;

endmodule
